// File: rtl/seq_detect_ctrl.sv
// Session controller for the serial sequence detector: serialises handshaked words MSB-first,
// clears the detector at session start and counts its hits until exhaustion, limit or abort.
module seq_detect_ctrl #(
    parameter int unsigned WORD_W       = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        word_count,
    input  logic [CNT_W-1:0]  hit_limit,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_clear,
    output logic              det_data,
    output logic              det_en,
    input  logic              det_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic              limit_reached
);

    localparam int unsigned CycMax = (WORD_W > DRAIN_CYCLES) ? WORD_W : DRAIN_CYCLES;
    localparam int unsigned CycW   = $clog2(CycMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic [7:0]        words_q, words_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d;
    logic              limit_reached_q, limit_reached_d;
    logic              abort_clr_q, abort_clr_d;

    logic              count_en;
    logic [CNT_W-1:0]  hit_sat;
    logic              limit_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            cyc_q           <= '0;
            words_q         <= '0;
            limit_q         <= '0;
            shreg_q         <= '0;
            hit_count_q     <= '0;
            limit_reached_q <= 1'b0;
            abort_clr_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cyc_q           <= cyc_d;
            words_q         <= words_d;
            limit_q         <= limit_d;
            shreg_q         <= shreg_d;
            hit_count_q     <= hit_count_d;
            limit_reached_q <= limit_reached_d;
            abort_clr_q     <= abort_clr_d;
        end
    end

    always_comb begin
        count_en  = (state_q == StClear) || (state_q == StLoad) ||
                    (state_q == StShift) || (state_q == StDrain);
        hit_sat   = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_W'(1);
        limit_hit = count_en && det_hit && (limit_q != '0) && (hit_sat == limit_q);
    end

    always_comb begin
        state_d         = state_q;
        cyc_d           = cyc_q;
        words_d         = words_q;
        limit_d         = limit_q;
        shreg_d         = shreg_q;
        hit_count_d     = hit_count_q;
        limit_reached_d = limit_reached_q;
        abort_clr_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    words_d         = word_count;
                    limit_d         = hit_limit;
                    hit_count_d     = '0;
                    limit_reached_d = 1'b0;
                    state_d         = StClear;
                end
            end
            StClear: begin
                cyc_d   = '0;
                state_d = (words_q == 8'd0) ? StDrain : StLoad;
            end
            StLoad: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    words_d = words_q - 8'd1;
                    cyc_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                cyc_d   = cyc_q + CycW'(1);
                if (cyc_q == CycW'(WORD_W - 1)) begin
                    cyc_d   = '0;
                    state_d = (words_q != 8'd0) ? StLoad : StDrain;
                end
            end
            StDrain: begin
                cyc_d = cyc_q + CycW'(1);
                if (cyc_q == CycW'(DRAIN_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (count_en && det_hit) begin
            hit_count_d = hit_sat;
        end
        // Reaching the limit ends the session; a partially shifted word is dropped.
        if (limit_hit) begin
            limit_reached_d = 1'b1;
            cyc_d           = '0;
            state_d         = StDone;
        end
        // Abort overrides everything else and leaves the counters untouched.
        if (abort && (state_q != StIdle)) begin
            state_d         = StIdle;
            hit_count_d     = hit_count_q;
            limit_reached_d = limit_reached_q;
            cyc_d           = '0;
            abort_clr_d     = 1'b1;
        end
    end

    always_comb begin
        in_ready      = (state_q == StLoad);
        det_clear     = (state_q == StClear) || abort_clr_q;
        det_en        = (state_q == StShift);
        det_data      = (state_q == StShift) && shreg_q[WORD_W-1];
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        hit_count     = hit_count_q;
        limit_reached = limit_reached_q;
    end

endmodule
